// File: rtl/talco_tile_scheduler.sv
// Tile sequencer for the TALCO X-Drop kernel: fetches each tile's ref/query words,
// loads the kernel BRAMs, runs the kernel and advances the tile origin.
// Optional perf counters are enabled by defining TALCO_SCHED_PERF_EN.
module talco_tile_scheduler #(
  parameter int REF_LEN_WIDTH     = 16,
  parameter int QUERY_LEN_WIDTH   = 16,
  parameter int MAX_TILE_SIZE     = 512,
  parameter int LOG_MAX_TILE_SIZE = 9,
  parameter int TILE_WORDS        = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [REF_LEN_WIDTH-1:0]     job_ref_len,
  input  logic [QUERY_LEN_WIDTH-1:0]   job_query_len,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_sel,
  output logic [15:0]                  mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [31:0]                  mem_rsp_data,
  output logic                         ref_wr_en,
  output logic [LOG_MAX_TILE_SIZE-3:0] ref_addr_in,
  output logic [31:0]                  ref_bram_data_in,
  output logic                         query_wr_en,
  output logic [LOG_MAX_TILE_SIZE-3:0] query_addr_in,
  output logic [31:0]                  query_bram_data_in,
  output logic                         start,
  output logic [1:0]                   init_state,
  output logic [1:0]                   ref_start_offset,
  output logic [1:0]                   query_start_offset,
  input  logic                         stop,
  input  logic                         last_tile,
  input  logic [REF_LEN_WIDTH-1:0]     ref_next_tile_addr,
  input  logic [QUERY_LEN_WIDTH-1:0]   query_next_tile_addr,
  input  logic [1:0]                   next_tile_init_state,
  output logic                         done,
  output logic                         error,
  output logic [15:0]                  tile_count
`ifdef TALCO_SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_load_cycles,
  output logic [31:0]                  perf_run_cycles
`endif
);

  // Words per tile can never exceed the kernel BRAM depth.
  localparam int WORDS_CAP = (TILE_WORDS < MAX_TILE_SIZE / 4) ? TILE_WORDS : MAX_TILE_SIZE / 4;
  localparam int ADDR_W    = LOG_MAX_TILE_SIZE - 2;
  localparam int CNT_W     = $clog2(WORDS_CAP + 1);

  localparam logic [REF_LEN_WIDTH-1:0]   R_ONE = REF_LEN_WIDTH'(1);
  localparam logic [QUERY_LEN_WIDTH-1:0] Q_ONE = QUERY_LEN_WIDTH'(1);
  localparam logic [REF_LEN_WIDTH-1:0]   R_CAP = REF_LEN_WIDTH'(WORDS_CAP);
  localparam logic [QUERY_LEN_WIDTH-1:0] Q_CAP = QUERY_LEN_WIDTH'(WORDS_CAP);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_REF, S_LOAD_QRY, S_START, S_RUN, S_ADVANCE, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [REF_LEN_WIDTH-1:0]   ref_len_q, ref_pos_q, ref_adv_q;
  logic [QUERY_LEN_WIDTH-1:0] qry_len_q, qry_pos_q, qry_adv_q;
  logic [1:0]                 init_state_q, nxt_init_q;
  logic [15:0]                tile_count_q;
  logic                       error_q;
  logic [CNT_W-1:0]           req_cnt_q, rsp_cnt_q;

  logic [REF_LEN_WIDTH-1:0]   ref_span;
  logic [QUERY_LEN_WIDTH-1:0] qry_span;
  logic [CNT_W-1:0]           ref_words, qry_words, cur_words;
  logic [REF_LEN_WIDTH:0]     ref_sum;
  logic [QUERY_LEN_WIDTH:0]   qry_sum;
  logic                       ref_past, qry_past, no_progress;
  logic                       req_fire, rsp_take, in_load, job_accept;

  // Words still to fetch from the tile origin to the last word of the sequence, capped.
  assign ref_span  = ((ref_len_q - R_ONE) >> 2) - (ref_pos_q >> 2) + R_ONE;
  assign qry_span  = ((qry_len_q - Q_ONE) >> 2) - (qry_pos_q >> 2) + Q_ONE;
  assign ref_words = (ref_span > R_CAP) ? CNT_W'(WORDS_CAP) : ref_span[CNT_W-1:0];
  assign qry_words = (qry_span > Q_CAP) ? CNT_W'(WORDS_CAP) : qry_span[CNT_W-1:0];
  assign cur_words = (state_q == S_LOAD_QRY) ? qry_words : ref_words;
  assign in_load   = (state_q == S_LOAD_REF) || (state_q == S_LOAD_QRY);
  assign job_accept = (state_q == S_IDLE) && job_valid;

  // Extra carry bit so an overflowing advance still compares as past the end.
  assign ref_sum     = {1'b0, ref_pos_q} + {1'b0, ref_adv_q};
  assign qry_sum     = {1'b0, qry_pos_q} + {1'b0, qry_adv_q};
  assign ref_past    = ref_sum >= {1'b0, ref_len_q};
  assign qry_past    = qry_sum >= {1'b0, qry_len_q};
  assign no_progress = (ref_adv_q == '0) && (qry_adv_q == '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d            = state_q;
    job_ready          = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_sel        = 1'b0;
    mem_req_addr       = '0;
    ref_wr_en          = 1'b0;
    ref_addr_in        = '0;
    ref_bram_data_in   = '0;
    query_wr_en        = 1'b0;
    query_addr_in      = '0;
    query_bram_data_in = '0;
    start              = 1'b0;
    done               = 1'b0;
    req_fire           = 1'b0;
    rsp_take           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_d = S_LOAD_REF;
      end
      S_LOAD_REF, S_LOAD_QRY: begin
        mem_req_sel   = (state_q == S_LOAD_QRY);
        mem_req_valid = (req_cnt_q < cur_words);
        if (mem_req_valid) begin
          mem_req_addr = (mem_req_sel ? 16'(qry_pos_q >> 2) : 16'(ref_pos_q >> 2)) + 16'(req_cnt_q);
        end
        req_fire = mem_req_valid && mem_req_ready;
        rsp_take = mem_rsp_valid && (rsp_cnt_q < cur_words);
        if (rsp_take) begin
          if (state_q == S_LOAD_REF) begin
            ref_wr_en        = 1'b1;
            ref_addr_in      = rsp_cnt_q[ADDR_W-1:0];
            ref_bram_data_in = mem_rsp_data;
          end else begin
            query_wr_en        = 1'b1;
            query_addr_in      = rsp_cnt_q[ADDR_W-1:0];
            query_bram_data_in = mem_rsp_data;
          end
          if (rsp_cnt_q == cur_words - CNT_W'(1)) begin
            state_d = (state_q == S_LOAD_REF) ? S_LOAD_QRY : S_START;
          end
        end
      end
      S_START: begin
        start   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) state_d = last_tile ? S_DONE : S_ADVANCE;
      end
      S_ADVANCE: begin
        if (no_progress || ref_past || qry_past) state_d = S_DONE;
        else                                      state_d = S_LOAD_REF;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_len_q    <= '0;
      qry_len_q    <= '0;
      ref_pos_q    <= '0;
      qry_pos_q    <= '0;
      ref_adv_q    <= '0;
      qry_adv_q    <= '0;
      init_state_q <= '0;
      nxt_init_q   <= '0;
      tile_count_q <= '0;
      error_q      <= 1'b0;
      req_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
    end else begin
      if (job_accept) begin
        ref_len_q    <= job_ref_len;
        qry_len_q    <= job_query_len;
        ref_pos_q    <= '0;
        qry_pos_q    <= '0;
        init_state_q <= '0;
        tile_count_q <= '0;
        error_q      <= 1'b0;
      end
      // Request and response counters restart on every state change.
      if (state_d != state_q) begin
        req_cnt_q <= '0;
        rsp_cnt_q <= '0;
      end else begin
        if (req_fire) req_cnt_q <= req_cnt_q + CNT_W'(1);
        if (rsp_take) rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
      end
      if (start && (tile_count_q != '1)) tile_count_q <= tile_count_q + 16'd1;
      // Kernel advance info is only valid alongside stop, so capture it there.
      if ((state_q == S_RUN) && stop) begin
        ref_adv_q  <= ref_next_tile_addr;
        qry_adv_q  <= query_next_tile_addr;
        nxt_init_q <= next_tile_init_state;
      end
      if (state_q == S_ADVANCE) begin
        if (no_progress) begin
          error_q <= 1'b1;
        end else begin
          ref_pos_q    <= ref_sum[REF_LEN_WIDTH-1:0];
          qry_pos_q    <= qry_sum[QUERY_LEN_WIDTH-1:0];
          init_state_q <= nxt_init_q;
        end
      end
    end
  end

  assign init_state         = init_state_q;
  assign ref_start_offset   = ref_pos_q[1:0];
  assign query_start_offset = qry_pos_q[1:0];
  assign tile_count         = tile_count_q;
  assign error              = error_q;

`ifdef TALCO_SCHED_PERF_EN
  logic [31:0] perf_load_q, perf_run_q;

  always_ff @(posedge clk) begin
    if (rst || job_accept) begin
      perf_load_q <= '0;
      perf_run_q  <= '0;
    end else begin
      if (in_load && (perf_load_q != '1))            perf_load_q <= perf_load_q + 32'd1;
      if ((state_q == S_RUN) && (perf_run_q != '1)) perf_run_q  <= perf_run_q + 32'd1;
    end
  end

  assign perf_load_cycles = perf_load_q;
  assign perf_run_cycles  = perf_run_q;
`else
  logic unused_in_load;
  assign unused_in_load = in_load;
`endif

endmodule

// File: tb/tb_talco_tile_scheduler.sv
// Self-checking bench for talco_tile_scheduler: memory and kernel models, table-driven jobs,
// hand-written reset/stray-stop sequences and randomized jobs against a tile-level reference model.
module tb_talco_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [15:0] job_ref_len, job_query_len;
  logic        mem_req_valid, mem_req_ready, mem_req_sel;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        ref_wr_en, query_wr_en;
  logic [6:0]  ref_addr_in, query_addr_in;
  logic [31:0] ref_bram_data_in, query_bram_data_in;
  logic        start;
  logic [1:0]  init_state, ref_start_offset, query_start_offset;
  logic        stop, last_tile;
  logic [15:0] ref_next_tile_addr, query_next_tile_addr;
  logic [1:0]  next_tile_init_state;
  logic        done, error;
  logic [15:0] tile_count;
`ifdef TALCO_SCHED_PERF_EN
  logic [31:0] perf_load_cycles, perf_run_cycles;
`endif

  talco_tile_scheduler dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_ref_len(job_ref_len), .job_query_len(job_query_len),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_sel(mem_req_sel), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ref_wr_en(ref_wr_en), .ref_addr_in(ref_addr_in), .ref_bram_data_in(ref_bram_data_in),
    .query_wr_en(query_wr_en), .query_addr_in(query_addr_in), .query_bram_data_in(query_bram_data_in),
    .start(start), .init_state(init_state),
    .ref_start_offset(ref_start_offset), .query_start_offset(query_start_offset),
    .stop(stop), .last_tile(last_tile),
    .ref_next_tile_addr(ref_next_tile_addr), .query_next_tile_addr(query_next_tile_addr),
    .next_tile_init_state(next_tile_init_state),
    .done(done), .error(error), .tile_count(tile_count)
`ifdef TALCO_SCHED_PERF_EN
    , .perf_load_cycles(perf_load_cycles), .perf_run_cycles(perf_run_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Job record: lengths, constant per-tile advances, index of the tile reporting last_tile,
  // memory latency, ready pattern (0 always, 1 toggle, 2 random), expected tile_count and error.
  typedef struct {
    int rl; int ql; int ra; int qa; int last_idx; int lat; int mode; int exp_tiles; int exp_err;
  } vec_t;
  typedef struct { logic sel; int addr; } req_t;
  typedef struct { logic sel; int addr; logic [31:0] data; } wr_t;
  typedef struct { int due; logic [31:0] data; } pend_t;

  int n_total = 0;
  int n_pass  = 0;

  int cyc = 0;
  int cfg_lat = 1, cfg_mode = 0, cfg_ra = 0, cfg_qa = 0, cfg_last = 0, cfg_kdelay = 50;
  int poke_cnt = 0;
  pend_t pend[$];
  req_t  got_req[$];
  wr_t   got_wr[$];
  int    got_wcum[$], got_roff[$], got_qoff[$], got_init[$];
  int    done_cnt = 0;
  bit    kern_busy = 1'b0;
  int    kern_left = 0, kern_tile = 0;

  req_t  exp_req[$];
  wr_t   exp_wr[$];
  int    exp_wcum[$], exp_roff[$], exp_qoff[$], exp_init[$];
  int    exp_tiles_m, exp_err_m;

  function automatic logic [31:0] memw(input logic sel, input int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B1;
    return sel ? ~h : (h ^ 32'h0F0F_0000);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Memory and kernel environment: drive inputs at negedge, observe DUT just after.
  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    stop = 1'b0; last_tile = 1'b0;
    ref_next_tile_addr = '0; query_next_tile_addr = '0; next_tile_init_state = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (rst) begin
        pend.delete();
        kern_busy = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend[0].data;
        void'(pend.pop_front());
      end
      case (cfg_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = cyc[0];
        default: mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      stop = 1'b0; last_tile = 1'b0;
      ref_next_tile_addr = '0; query_next_tile_addr = '0; next_tile_init_state = '0;
      if (poke_cnt > 0) begin
        stop = 1'b1; last_tile = 1'b1; ref_next_tile_addr = 16'd4;
        poke_cnt--;
      end else if (kern_busy) begin
        if (kern_left == 0) begin
          stop = 1'b1;
          last_tile = (kern_tile == cfg_last);
          ref_next_tile_addr   = 16'(cfg_ra);
          query_next_tile_addr = 16'(cfg_qa);
          next_tile_init_state = 2'((kern_tile % 3) + 1);
          kern_busy = 1'b0;
        end else begin
          kern_left--;
        end
      end
      #1;
      if (mem_req_valid && mem_req_ready) begin
        req_t r;
        pend_t p;
        r.sel = mem_req_sel; r.addr = int'(mem_req_addr);
        got_req.push_back(r);
        p.due = cyc + cfg_lat; p.data = memw(mem_req_sel, int'(mem_req_addr));
        pend.push_back(p);
      end
      if (ref_wr_en) begin
        wr_t w;
        w.sel = 1'b0; w.addr = int'(ref_addr_in); w.data = ref_bram_data_in;
        got_wr.push_back(w);
      end
      if (query_wr_en) begin
        wr_t w;
        w.sel = 1'b1; w.addr = int'(query_addr_in); w.data = query_bram_data_in;
        got_wr.push_back(w);
      end
      if (start) begin
        got_wcum.push_back(got_wr.size());
        got_roff.push_back(int'(ref_start_offset));
        got_qoff.push_back(int'(query_start_offset));
        got_init.push_back(int'(init_state));
        kern_tile = got_wcum.size() - 1;
        kern_left = cfg_kdelay;
        kern_busy = 1'b1;
      end
      if (done) done_cnt++;
    end
  end

  // Tile-level reference: walk the tile origins with plain integer arithmetic.
  task automatic model(input vec_t v);
    int rp, qp, nr, nq;
    rp = 0; qp = 0;
    exp_req.delete(); exp_wr.delete();
    exp_wcum.delete(); exp_roff.delete(); exp_qoff.delete(); exp_init.delete();
    exp_err_m = 0; exp_tiles_m = 0;
    for (int t = 0; t < 64; t++) begin
      nr = (v.rl - 1) / 4 - rp / 4 + 1; if (nr > 128) nr = 128;
      nq = (v.ql - 1) / 4 - qp / 4 + 1; if (nq > 128) nq = 128;
      for (int k = 0; k < nr; k++) begin
        req_t r; wr_t w;
        r.sel = 1'b0; r.addr = rp / 4 + k; exp_req.push_back(r);
        w.sel = 1'b0; w.addr = k; w.data = memw(1'b0, rp / 4 + k); exp_wr.push_back(w);
      end
      for (int k = 0; k < nq; k++) begin
        req_t r; wr_t w;
        r.sel = 1'b1; r.addr = qp / 4 + k; exp_req.push_back(r);
        w.sel = 1'b1; w.addr = k; w.data = memw(1'b1, qp / 4 + k); exp_wr.push_back(w);
      end
      exp_wcum.push_back(exp_wr.size());
      exp_roff.push_back(rp % 4);
      exp_qoff.push_back(qp % 4);
      exp_init.push_back((t == 0) ? 0 : ((t - 1) % 3) + 1);
      exp_tiles_m = t + 1;
      if (t == v.last_idx) break;
      if (v.ra == 0 && v.qa == 0) begin exp_err_m = 1; break; end
      rp += v.ra; qp += v.qa;
      if (rp >= v.rl || qp >= v.ql) break;
    end
  endtask

  task automatic clear_obs();
    got_req.delete(); got_wr.delete();
    got_wcum.delete(); got_roff.delete(); got_qoff.delete(); got_init.delete();
    done_cnt = 0;
  endtask

  task automatic run_job(input vec_t v, input int kdelay, input string tag);
    int mism, et, ee;
    cfg_lat = v.lat; cfg_mode = v.mode; cfg_ra = v.ra; cfg_qa = v.qa;
    cfg_last = v.last_idx; cfg_kdelay = kdelay;
    clear_obs();
    @(negedge clk);
    job_valid = 1'b1; job_ref_len = 16'(v.rl); job_query_len = 16'(v.ql);
    @(negedge clk);
    job_valid = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #2;
    model(v);
    et = (v.exp_tiles < 0) ? exp_tiles_m : v.exp_tiles;
    ee = (v.exp_err < 0) ? exp_err_m : v.exp_err;
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".tile_count"}, int'(tile_count), et);
    check({tag, ".error"}, int'(error), ee);
    check({tag, ".job_ready"}, int'(job_ready), 1);
    check({tag, ".starts"}, got_wcum.size(), exp_wcum.size());
    check({tag, ".req_count"}, got_req.size(), exp_req.size());
    mism = 0;
    for (int i = 0; i < got_req.size() && i < exp_req.size(); i++)
      if (got_req[i].sel !== exp_req[i].sel || got_req[i].addr != exp_req[i].addr) mism++;
    check({tag, ".req_seq_mismatches"}, mism, 0);
    check({tag, ".wr_count"}, got_wr.size(), exp_wr.size());
    mism = 0;
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      if (got_wr[i].sel !== exp_wr[i].sel || got_wr[i].addr != exp_wr[i].addr ||
          got_wr[i].data !== exp_wr[i].data) mism++;
    check({tag, ".wr_seq_mismatches"}, mism, 0);
    mism = 0;
    for (int i = 0; i < got_wcum.size() && i < exp_wcum.size(); i++)
      if (got_wcum[i] != exp_wcum[i] || got_roff[i] != exp_roff[i] ||
          got_qoff[i] != exp_qoff[i] || got_init[i] != exp_init[i]) mism++;
    check({tag, ".start_info_mismatches"}, mism, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int qw;
    vec_t r;
    vecs[0] = '{100,   100,  0,     0,   0, 1, 0, 1, 0};
    vecs[1] = '{1200,  1200, 400,   380, 2, 1, 0, 3, 0};
    vecs[2] = '{100,   100,  0,     0,   5, 1, 0, 1, 1};
    vecs[3] = '{100,   100,  0,     0,   0, 7, 1, 1, 0};
    vecs[4] = '{1000,  1000, 1001,  10,  5, 2, 0, 1, 0};
    vecs[5] = '{65535, 200,  40000, 10,  5, 1, 0, 2, 0};
    vecs[6] = '{37,    50,   5,     6,   2, 3, 2, 3, 0};
    vecs[7] = '{4,     1,    0,     1,   3, 1, 0, 1, 0};

    rst = 1'b1; job_valid = 1'b0; job_ref_len = '0; job_query_len = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst.job_ready", int'(job_ready), 1);
    check("rst.mem_req_valid", int'(mem_req_valid), 0);
    check("rst.start", int'(start), 0);
    check("rst.done", int'(done), 0);
    check("rst.tile_count", int'(tile_count), 0);
    check("rst.error_init", int'({error, init_state, ref_start_offset, query_start_offset}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_job(vecs[i], 50, $sformatf("vec%0d", i));

    // Stop pulses while idle must be ignored.
    clear_obs();
    poke_cnt = 2;
    repeat (6) @(negedge clk);
    #2;
    check("stray_stop.job_ready", int'(job_ready), 1);
    check("stray_stop.done_pulses", done_cnt, 0);
    check("stray_stop.no_fetch", got_req.size(), 0);

    // Reset while the query words are loading.
    cfg_lat = 1; cfg_mode = 0; cfg_last = 0; cfg_kdelay = 50;
    clear_obs();
    @(negedge clk);
    job_valid = 1'b1; job_ref_len = 16'd100; job_query_len = 16'd100;
    @(negedge clk);
    job_valid = 1'b0;
    qw = 0;
    for (int i = 0; i < 2000 && qw < 10; i++) begin
      @(negedge clk);
      #2;
      qw = 0;
      foreach (got_wr[j]) if (got_wr[j].sel) qw++;
    end
    check("mid_rst.reached_qry_word10", qw, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("mid_rst.job_ready", int'(job_ready), 1);
    check("mid_rst.mem_req_valid", int'(mem_req_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("mid_rst.no_start", got_wcum.size(), 0);
    check("mid_rst.tile_count", int'(tile_count), 0);
    run_job(vecs[0], 50, "post_rst");

    for (int n = 0; n < 12; n++) begin
      r.rl = int'($urandom_range(1, 1500));
      r.ql = int'($urandom_range(1, 1500));
      r.ra = int'($urandom_range(0, 500));
      r.qa = int'($urandom_range(0, 500));
      if ($urandom_range(0, 5) == 0) begin r.ra = 0; r.qa = 0; end
      r.last_idx = int'($urandom_range(0, 3));
      r.lat = int'($urandom_range(1, 6));
      r.mode = int'($urandom_range(0, 2));
      r.exp_tiles = -1; r.exp_err = -1;
      run_job(r, int'($urandom_range(0, 20)), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
